knn_train_loader: RTL

Sequential writer for the packed training-set buses consumed by the combinational KNN classifier. It accepts labelled training points one per handshake into a shadow buffer. On the last point, or when the buffer is full, it commits the buffer atomically to the active buffer that drives the classifier. The classifier therefore never sees a partially loaded set.

---
 rtl/knn_pkg.sv | 23 ++
 rtl/knn_point_buffer.sv | 61 ++++++
 rtl/knn_train_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN training loader and classifier: default
// geometry, loader FSM encoding and packed-bus offset helpers.
package knn_pkg;

    localparam int DEF_NUM_POINTS = 8;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_LABEL_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic int coord_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int label_lsb(input int idx, input int label_w);
        return idx * label_w;
    endfunction

endpackage

// File: rtl/knn_point_buffer.sv
// Register file of {x, y, label} slots with an indexed write port, a bulk
// load port and packed read-out. Priority: clear, then bulk load, then write.
module knn_point_buffer
    import knn_pkg::*;
#(
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LABEL_W    = DEF_LABEL_W,
    parameter int ADDR_W     = $clog2(NUM_POINTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WIDTH-1:0]              wr_x,
    input  logic [WIDTH-1:0]              wr_y,
    input  logic [LABEL_W-1:0]            wr_label,
    input  logic                          load,
    input  logic [NUM_POINTS*WIDTH-1:0]   load_x,
    input  logic [NUM_POINTS*WIDTH-1:0]   load_y,
    input  logic [NUM_POINTS*LABEL_W-1:0] load_labels,
    output logic [NUM_POINTS*WIDTH-1:0]   rd_x,
    output logic [NUM_POINTS*WIDTH-1:0]   rd_y,
    output logic [NUM_POINTS*LABEL_W-1:0] rd_labels
);

    for (genvar gi = 0; gi < NUM_POINTS; gi++) begin : g_slot
        logic [WIDTH-1:0]   x_reg;
        logic [WIDTH-1:0]   y_reg;
        logic [LABEL_W-1:0] label_reg;
        logic               hit;

        assign hit = wr_en && (wr_addr == ADDR_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_reg     <= '0;
                y_reg     <= '0;
                label_reg <= '0;
            end else if (clear) begin
                x_reg     <= '0;
                y_reg     <= '0;
                label_reg <= '0;
            end else if (load) begin
                x_reg     <= load_x[coord_lsb(gi, WIDTH) +: WIDTH];
                y_reg     <= load_y[coord_lsb(gi, WIDTH) +: WIDTH];
                label_reg <= load_labels[label_lsb(gi, LABEL_W) +: LABEL_W];
            end else if (hit) begin
                x_reg     <= wr_x;
                y_reg     <= wr_y;
                label_reg <= wr_label;
            end
        end

        assign rd_x[coord_lsb(gi, WIDTH) +: WIDTH]                = x_reg;
        assign rd_y[coord_lsb(gi, WIDTH) +: WIDTH]                = y_reg;
        assign rd_labels[label_lsb(gi, LABEL_W) +: LABEL_W]       = label_reg;
    end

endmodule

// File: rtl/knn_train_loader.sv
// Loads labelled training points into a shadow buffer and commits the whole
// set atomically to the active buffer, so the classifier never sees a partial set.
module knn_train_loader
    import knn_pkg::*;
#(
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LABEL_W    = DEF_LABEL_W,
    parameter int CNT_W      = $clog2(NUM_POINTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_x,
    input  logic [WIDTH-1:0]              in_y,
    input  logic [LABEL_W-1:0]            in_label,
    input  logic                          in_last,
    output logic [NUM_POINTS*WIDTH-1:0]   train_x,
    output logic [NUM_POINTS*WIDTH-1:0]   train_y,
    output logic [NUM_POINTS*LABEL_W-1:0] train_labels,
    output logic [NUM_POINTS-1:0]         valid_mask,
    output logic                          set_valid,
    output logic                          commit_pulse,
    output logic [CNT_W-1:0]              count
);

    state_t                         state_reg;
    logic [CNT_W-1:0]               count_reg;
    logic [CNT_W-1:0]               count_next;
    logic                           in_ready_reg;
    logic                           set_valid_reg;
    logic                           commit_pulse_reg;
    logic [NUM_POINTS-1:0]          valid_mask_reg;
    logic [NUM_POINTS-1:0]          commit_mask;
    logic                           accept;
    logic                           commit_now;
    logic                           close_set;
    logic [NUM_POINTS*WIDTH-1:0]    shadow_x;
    logic [NUM_POINTS*WIDTH-1:0]    shadow_y;
    logic [NUM_POINTS*LABEL_W-1:0]  shadow_labels;

    // in_ready_reg is low only in COMMIT, so it doubles as the "can load" flag.
    assign accept     = in_valid && in_ready_reg && !clear;
    assign commit_now = (state_reg == ST_COMMIT) && !clear;
    assign count_next = count_reg + CNT_W'(1);
    assign close_set  = in_last || (count_next == CNT_W'(NUM_POINTS));

    for (genvar gi = 0; gi < NUM_POINTS; gi++) begin : g_mask
        assign commit_mask[gi] = (CNT_W'(gi) < count_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            count_reg        <= '0;
            in_ready_reg     <= 1'b1;
            set_valid_reg    <= 1'b0;
            commit_pulse_reg <= 1'b0;
            valid_mask_reg   <= '0;
        end else if (clear) begin
            state_reg        <= ST_IDLE;
            count_reg        <= '0;
            in_ready_reg     <= 1'b1;
            set_valid_reg    <= 1'b0;
            commit_pulse_reg <= 1'b0;
            valid_mask_reg   <= '0;
        end else begin
            commit_pulse_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        count_reg <= count_next;
                        if (close_set) begin
                            state_reg    <= ST_COMMIT;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg    <= ST_LOAD;
                        end
                    end
                end
                ST_COMMIT: begin
                    valid_mask_reg   <= commit_mask;
                    set_valid_reg    <= 1'b1;
                    commit_pulse_reg <= 1'b1;
                    count_reg        <= '0;
                    in_ready_reg     <= 1'b1;
                    state_reg        <= ST_IDLE;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    count_reg    <= '0;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Shadow empties on the commit edge, so unloaded slots always commit as zero.
    knn_point_buffer #(
        .NUM_POINTS (NUM_POINTS),
        .WIDTH      (WIDTH),
        .LABEL_W    (LABEL_W),
        .ADDR_W     (CNT_W)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear || (state_reg == ST_COMMIT)),
        .wr_en       (accept),
        .wr_addr     (count_reg),
        .wr_x        (in_x),
        .wr_y        (in_y),
        .wr_label    (in_label),
        .load        (1'b0),
        .load_x      ('0),
        .load_y      ('0),
        .load_labels ('0),
        .rd_x        (shadow_x),
        .rd_y        (shadow_y),
        .rd_labels   (shadow_labels)
    );

    knn_point_buffer #(
        .NUM_POINTS (NUM_POINTS),
        .WIDTH      (WIDTH),
        .LABEL_W    (LABEL_W),
        .ADDR_W     (CNT_W)
    ) u_active (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .wr_en       (1'b0),
        .wr_addr     ('0),
        .wr_x        ('0),
        .wr_y        ('0),
        .wr_label    ('0),
        .load        (commit_now),
        .load_x      (shadow_x),
        .load_y      (shadow_y),
        .load_labels (shadow_labels),
        .rd_x        (train_x),
        .rd_y        (train_y),
        .rd_labels   (train_labels)
    );

    assign in_ready     = in_ready_reg;
    assign set_valid    = set_valid_reg;
    assign commit_pulse = commit_pulse_reg;
    assign valid_mask   = valid_mask_reg;
    assign count        = count_reg;

endmodule
